// File: rtl/ucsbece154a_selfcheck_if.sv
// Table and debug-read bundle between the self-check controller (master)
// and the expected-value table / core debug ports (slave).
interface ucsbece154a_selfcheck_if #(
  parameter int IW = 4
);
  logic [IW-1:0] chk_idx;
  logic          chk_is_mem;
  logic [31:0]   chk_addr;
  logic [31:0]   chk_exp;
  logic [4:0]    dbg_rf_addr;
  logic [31:0]   dbg_rf_data;
  logic [31:0]   dbg_mem_addr;
  logic [31:0]   dbg_mem_data;

  modport master (
    output chk_idx, dbg_rf_addr, dbg_mem_addr,
    input  chk_is_mem, chk_addr, chk_exp, dbg_rf_data, dbg_mem_data
  );

  modport slave (
    input  chk_idx, dbg_rf_addr, dbg_mem_addr,
    output chk_is_mem, chk_addr, chk_exp, dbg_rf_data, dbg_mem_data
  );
endinterface

// File: rtl/ucsbece154a_selfcheck.sv
// Run-and-check controller: holds the core in reset, runs it for a bounded
// number of cycles (or until halt), then walks an expected-value table.
module ucsbece154a_selfcheck #(
  parameter int NUM_CHECKS   = 10,
  parameter int RUN_CYCLES   = 75,
  parameter int RESET_CYCLES = 1,
  parameter bit HALT_EN      = 1'b0,
  parameter int CW           = 16,
  parameter int IW           = $clog2(NUM_CHECKS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    halt,
  output logic                    core_reset,
  output logic                    core_run,
  ucsbece154a_selfcheck_if.master chk,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [IW-1:0]           fail_count,
  output logic [IW-1:0]           first_fail,
  output logic                    halted,
  output logic                    timeout,
  output logic [CW-1:0]           cycle_count
);
  localparam int RSW = $clog2(RESET_CYCLES + 1);
  localparam int RUW = $clog2(RUN_CYCLES + 1);
  localparam logic [IW-1:0] NONE = IW'(NUM_CHECKS);
  localparam logic [IW-1:0] LAST = IW'(NUM_CHECKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_CHECK, S_DONE} state_t;

  state_t         state, state_next;
  logic [RSW-1:0] rst_cnt;
  logic [RUW-1:0] run_cnt;
  logic [IW-1:0]  idx;
  logic           rst_last, run_last, halt_hit, chk_last, mismatch;
  logic [31:0]    actual;
  logic           core_reset_d, core_run_d, busy_d, done_d;

  assign chk.chk_idx      = idx;
  assign chk.dbg_rf_addr  = chk.chk_addr[4:0];
  assign chk.dbg_mem_addr = {chk.chk_addr[31:2], 2'b00};

  assign rst_last = (rst_cnt == RSW'(RESET_CYCLES - 1));
  assign run_last = (run_cnt == RUW'(RUN_CYCLES - 1));
  assign halt_hit = HALT_EN && halt;
  assign chk_last = (idx == LAST);
  assign actual   = chk.chk_is_mem ? chk.dbg_mem_data : chk.dbg_rf_data;
  assign mismatch = (actual != chk.chk_exp);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_next = S_RESET;
      S_RESET:        if (rst_last) state_next = S_RUN;
      S_RUN:          if (halt_hit || run_last) state_next = S_CHECK;
      S_CHECK:        if (chk_last) state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  // Control outputs decode the next state so the registered copies
  // change on the same edge as the state register.
  always_comb begin
    core_reset_d = (state_next == S_IDLE) || (state_next == S_RESET);
    core_run_d   = (state_next == S_RUN);
    busy_d       = (state_next == S_RESET) || (state_next == S_RUN) ||
                   (state_next == S_CHECK);
    done_d       = (state_next == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      core_reset  <= 1'b1;
      core_run    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_count  <= '0;
      first_fail  <= NONE;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      idx         <= '0;
      rst_cnt     <= '0;
      run_cnt     <= '0;
    end else begin
      core_reset <= core_reset_d;
      core_run   <= core_run_d;
      busy       <= busy_d;
      done       <= done_d;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pass        <= 1'b0;
            fail_count  <= '0;
            first_fail  <= NONE;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            idx         <= '0;
            rst_cnt     <= '0;
          end
        end
        S_RESET: begin
          rst_cnt <= rst_cnt + 1'b1;
          run_cnt <= '0;
        end
        S_RUN: begin
          run_cnt <= run_cnt + 1'b1;
          if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
          // halt wins over a coincident terminal count
          if (halt_hit)      halted  <= 1'b1;
          else if (run_last) timeout <= HALT_EN;
        end
        S_CHECK: begin
          if (mismatch) begin
            fail_count <= fail_count + 1'b1;
            if (first_fail == NONE) first_fail <= idx;
          end
          if (chk_last) begin
            idx  <= '0;
            pass <= (fail_count == '0) && !mismatch;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ucsbece154a_selfcheck.sv
// Bench for ucsbece154a_selfcheck: one instance with halt disabled, one with
// halt enabled, both reading a behavioural register file / data memory.
module tb_ucsbece154a_selfcheck;
  localparam int N  = 10;
  localparam int RC = 75;
  localparam int RS = 1;
  localparam int CW = 16;
  localparam int IW = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, halt;
  logic start [2];
  logic core_reset [2], core_run [2], busy [2], done [2], pass [2];
  logic halted [2], timeout [2];
  logic [IW-1:0] fail_count [2], first_fail [2];
  logic [CW-1:0] cycle_count [2];

  logic [31:0] rf [32];
  logic [31:0] mem [64];
  logic        ism_tab [16];
  logic [31:0] addr_tab [16];
  logic [31:0] exp_tab [16];

  int checks = 0;
  int failures = 0;

  ucsbece154a_selfcheck_if #(.IW(IW)) cif0 ();
  ucsbece154a_selfcheck_if #(.IW(IW)) cif1 ();

  ucsbece154a_selfcheck #(.HALT_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .halt(halt),
    .core_reset(core_reset[0]), .core_run(core_run[0]), .chk(cif0),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .fail_count(fail_count[0]), .first_fail(first_fail[0]),
    .halted(halted[0]), .timeout(timeout[0]), .cycle_count(cycle_count[0])
  );

  ucsbece154a_selfcheck #(.HALT_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .halt(halt),
    .core_reset(core_reset[1]), .core_run(core_run[1]), .chk(cif1),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .fail_count(fail_count[1]), .first_fail(first_fail[1]),
    .halted(halted[1]), .timeout(timeout[1]), .cycle_count(cycle_count[1])
  );

  // Unaligned or out-of-window reads return junk so address masking matters.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (a[1:0] != 2'b00 || off >= 32'd256) return 32'hBAD0_0000 ^ a;
    return mem[off[7:2]];
  endfunction

  always_comb begin
    cif0.chk_is_mem   = ism_tab[cif0.chk_idx];
    cif0.chk_addr     = addr_tab[cif0.chk_idx];
    cif0.chk_exp      = exp_tab[cif0.chk_idx];
    cif0.dbg_rf_data  = rf[cif0.dbg_rf_addr];
    cif0.dbg_mem_data = mem_rd(cif0.dbg_mem_addr);
  end

  always_comb begin
    cif1.chk_is_mem   = ism_tab[cif1.chk_idx];
    cif1.chk_addr     = addr_tab[cif1.chk_idx];
    cif1.chk_exp      = exp_tab[cif1.chk_idx];
    cif1.dbg_rf_data  = rf[cif1.dbg_rf_addr];
    cif1.dbg_mem_data = mem_rd(cif1.dbg_mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] idx_of(input int sel);
    return (sel == 0) ? cif0.chk_idx : cif1.chk_idx;
  endfunction

  function automatic logic [31:0] entry_actual(input int i);
    return ism_tab[i] ? mem_rd({addr_tab[i][31:2], 2'b00}) : rf[addr_tab[i][4:0]];
  endfunction

  task automatic set_entry(input int i, input logic m, input logic [31:0] a, input logic [31:0] e);
    ism_tab[i]  = m;
    addr_tab[i] = a;
    exp_tab[i]  = e;
  endtask

  task automatic load_program(input bit wrong);
    for (int i = 0; i < 32; i++) rf[i] = 32'h5a5a_0000 + i;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    rf[0] = 0; rf[2] = 7; rf[3] = 32'hc; rf[4] = 1; rf[5] = 32'hb; rf[7] = 7;
    rf[16] = 32'h1000_0000; rf[17] = 32'h1000_000c;
    mem[20] = 7; mem[21] = 7;
    for (int i = 0; i < 16; i++) set_entry(i, 1'b0, 32'h0, 32'h0);
    set_entry(0, 1'b0, 2,  7);
    set_entry(1, 1'b0, 3,  32'hc);
    set_entry(2, 1'b0, 4,  1);
    set_entry(3, 1'b0, 5,  wrong ? 32'ha : 32'hb);
    set_entry(4, 1'b0, 7,  7);
    set_entry(5, 1'b0, 16, 32'h1000_0000);
    set_entry(6, 1'b0, 17, 32'h1000_000c);
    set_entry(7, 1'b1, 32'h1000_0050, wrong ? 32'h8 : 32'h7);
    set_entry(8, 1'b1, 32'h1000_0054, 7);
    set_entry(9, 1'b0, 0,  0);
  endtask

  task automatic load_random(input int nwrong);
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    for (int i = 0; i < 16; i++) begin
      if (i < N && ($urandom % 2) == 1)
        set_entry(i, 1'b1, BASE + ($urandom_range(63) << 2) + $urandom_range(3), 0);
      else
        set_entry(i, 1'b0, ($urandom & ~32'h1f) | $urandom_range(31), 0);
      exp_tab[i] = entry_actual(i);
    end
    for (int k = 0; k < nwrong; k++) begin
      int j;
      j = $urandom_range(N - 1);
      exp_tab[j] = entry_actual(j) ^ (32'h1 << $urandom_range(31));
    end
  endtask

  task automatic check_idle(input int sel, input string tag);
    check({tag, ".core_reset"},  core_reset[sel],  1);
    check({tag, ".core_run"},    core_run[sel],    0);
    check({tag, ".busy"},        busy[sel],        0);
    check({tag, ".done"},        done[sel],        0);
    check({tag, ".pass"},        pass[sel],        0);
    check({tag, ".fail_count"},  fail_count[sel],  0);
    check({tag, ".first_fail"},  first_fail[sel],  N);
    check({tag, ".halted"},      halted[sel],      0);
    check({tag, ".timeout"},     timeout[sel],     0);
    check({tag, ".cycle_count"}, cycle_count[sel], 0);
    check({tag, ".chk_idx"},     idx_of(sel),      0);
  endtask

  // Edge e=0 is the edge that samples start; halt for RUN cycle k is
  // sampled at edge RS+k.
  task automatic run_and_check(input int sel, input int halt_k, input bit poke, input string tag);
    int exp_run, exp_fails, exp_ff, done_e, run_seen;
    bit exp_halted, exp_to;
    exp_fails = 0;
    exp_ff = N;
    for (int i = 0; i < N; i++)
      if (entry_actual(i) != exp_tab[i]) begin
        exp_fails++;
        if (exp_ff == N) exp_ff = i;
      end
    if (sel == 1 && halt_k >= 1 && halt_k <= RC) begin
      exp_run = halt_k; exp_halted = 1; exp_to = 0;
    end else begin
      exp_run = RC; exp_halted = 0; exp_to = (sel == 1);
    end
    done_e = -1;
    run_seen = 0;
    for (int e = 0; e < RS + RC + N + 20; e++) begin
      start[sel] = (e == 0) || (poke && (e == RS + 20 || e == RS + RC + 3));
      halt = (halt_k > 0) && (e == RS + halt_k);
      @(posedge clk);
      @(negedge clk);
      if (core_run[sel]) run_seen++;
      if (e == 0) begin
        check({tag, ".busy0"},       busy[sel],        1);
        check({tag, ".done0"},       done[sel],        0);
        check({tag, ".pass0"},       pass[sel],        0);
        check({tag, ".fail_clr"},    fail_count[sel],  0);
        check({tag, ".ff_clr"},      first_fail[sel],  N);
        check({tag, ".cycle_clr"},   cycle_count[sel], 0);
      end
      if (e == RS - 1) check({tag, ".core_reset_held"}, core_reset[sel], 1);
      if (e == RS) begin
        check({tag, ".core_run_on"},  core_run[sel],   1);
        check({tag, ".core_rst_off"}, core_reset[sel], 0);
      end
      if (done[sel]) begin
        done_e = e;
        break;
      end
    end
    start[sel] = 1'b0;
    halt = 1'b0;
    check({tag, ".latency"},     done_e + 1,       RS + exp_run + N + 1);
    check({tag, ".run_cycles"},  run_seen,         exp_run);
    check({tag, ".pass"},        pass[sel],        exp_fails == 0);
    check({tag, ".fail_count"},  fail_count[sel],  exp_fails);
    check({tag, ".first_fail"},  first_fail[sel],  exp_ff);
    check({tag, ".halted"},      halted[sel],      exp_halted);
    check({tag, ".timeout"},     timeout[sel],     exp_to);
    check({tag, ".cycle_count"}, cycle_count[sel], exp_run);
    check({tag, ".busy_done"},   busy[sel],        0);
    check({tag, ".core_frozen"}, {core_reset[sel], core_run[sel]}, 2'b00);
    check({tag, ".chk_idx_done"}, idx_of(sel),     0);
    check({tag, ".dbg_rf_addr"},
          (sel == 0) ? cif0.dbg_rf_addr : cif1.dbg_rf_addr, addr_tab[0][4:0]);
    check({tag, ".dbg_mem_addr"},
          (sel == 0) ? cif0.dbg_mem_addr : cif1.dbg_mem_addr, {addr_tab[0][31:2], 2'b00});
  endtask

  task automatic reset_mid(input int sel, input int at_e, input string tag);
    for (int e = 0; e < at_e; e++) begin
      start[sel] = (e == 0);
      @(posedge clk);
      @(negedge clk);
    end
    start[sel] = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_idle(sel, tag);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".stays_idle"}, busy[sel], 0);
  endtask

  initial begin
    reset = 1'b1;
    halt = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    load_program(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle(0, "rst0");
    check_idle(1, "rst1");
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);

    run_and_check(0, 0, 1'b1, "prog_ok");
    load_program(1'b1);
    run_and_check(0, 0, 1'b0, "prog_bad");
    load_program(1'b0);
    run_and_check(1, 40, 1'b0, "halt40");
    run_and_check(1, 0, 1'b0, "no_halt");
    run_and_check(1, RC, 1'b0, "halt_at_tc");
    run_and_check(0, 40, 1'b1, "halt_ignored");

    load_program(1'b1);
    reset_mid(0, RS + 20, "rst_run");
    reset_mid(0, RS + RC + 6, "rst_check");
    load_program(1'b0);
    run_and_check(0, 0, 1'b0, "after_rst");

    for (int r = 0; r < 8; r++) begin
      int sel, hk;
      sel = r % 2;
      hk = (($urandom % 3) == 0) ? 0 : $urandom_range(1, 90);
      load_random($urandom_range(0, 3));
      run_and_check(sel, hk, (sel == 0) || (hk == 0) || (hk > RC), $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ucsbece154a_selfcheck.md
# ucsbece154a_selfcheck

Parametrised run-and-check controller for the multicycle MIPS core. It holds the core in reset, releases it for a bounded number of cycles, and optionally stops early on a core halt indication. It then freezes the core and walks an expected-value table, comparing each entry against register-file and data-memory debug read ports. It reports pass/fail, the failure count, the first failing entry and the run length, so that any program's end-state check is a table instead of hand-written assertions.

## Interface
- `NUM_CHECKS`, default 10: number of table entries checked; must be ≥1.
- `RUN_CYCLES`, default 75: maximum core run cycles after reset release; must be ≥1.
- `RESET_CYCLES`, default 1: cycles `core_reset` is held after `start`; must be ≥1.
- `HALT_EN`, default 0: 1 means the `halt` input ends RUN early.
- `CW`, default 16: width of `cycle_count`.
- `IW`, default `$clog2(NUM_CHECKS+1)`: width of index and count outputs.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; honoured only in IDLE or DONE.
- `halt`  in  1  core-finished indication; sampled only in RUN and only when `HALT_EN`=1.
- `core_reset`  out  1  reset to the core.
- `core_run`  out  1  clock-enable to the core.
- `chk_idx`  out  IW  table read index.
- `chk_is_mem`  in  1  entry type: 0 = register, 1 = memory. Combinational from `chk_idx`.
- `chk_addr`  in  32  register index in bits [4:0], or byte address when the entry is a memory entry.
- `chk_exp`  in  32  expected value.
- `dbg_rf_addr`  out  5  register-file debug read address, equal to `chk_addr[4:0]`.
- `dbg_rf_data`  in  32  combinational register read data.
- `dbg_mem_addr`  out  32  data-memory debug address, equal to `chk_addr` with bits [1:0] forced to 0.
- `dbg_mem_data`  in  32  combinational memory read data.
- `busy`  out  1  1 in RESET, RUN and CHECK.
- `done`  out  1  1 in DONE.
- `pass`  out  1  valid when `done`=1: `fail_count`==0.
- `fail_count`  out  IW  number of mismatching entries.
- `first_fail`  out  IW  index of the lowest failing entry; equals `NUM_CHECKS` if there is none.
- `halted`  out  1  RUN ended on `halt`.
- `timeout`  out  1  `HALT_EN`=1 and RUN ended without `halt`.
- `cycle_count`  out  CW  number of RUN cycles executed; saturates at all-ones.

## Operation
- States: IDLE, RESET, RUN, CHECK, DONE.
- On `reset`, from any state including mid-run or mid-check:
  - state goes to IDLE.
  - `core_reset`=1, `core_run`=0, `busy`=0, `done`=0, `pass`=0.
  - `fail_count`=0, `first_fail`=`NUM_CHECKS`, `halted`=0, `timeout`=0, `cycle_count`=0, `chk_idx`=0.
- IDLE:
  - `core_reset`=1.
  - `start` goes to RESET and clears all result outputs to their reset values.
- RESET:
  - `core_reset`=1, `core_run`=0.
  - After `RESET_CYCLES` cycles, go to RUN.
- RUN:
  - `core_reset`=0, `core_run`=1.
  - `cycle_count` increments once per RUN cycle.
  - Exit to CHECK after the `RUN_CYCLES`-th RUN cycle, or on the first cycle with `HALT_EN`=1 and `halt`=1.
  - When the run ends on `halt`, that cycle is counted and `halted` is set.
  - When `halt` and the terminal count occur in the same cycle, the result is `halted`=1, `timeout`=0.
  - `timeout`=1 only when `HALT_EN`=1 and the terminal count is reached without `halt`.
- CHECK:
  - `core_run`=0 (core frozen), `core_reset`=0.
  - One entry per cycle, `chk_idx` running 0..`NUM_CHECKS`-1.
  - Actual value = `chk_is_mem` ? `dbg_mem_data` : `dbg_rf_data`.
  - Mismatch increments `fail_count` at the clock edge.
  - `first_fail` is loaded with `chk_idx` only while it still equals `NUM_CHECKS`.
  - After the last index, go to DONE with `chk_idx`=0.
- DONE:
  - `core_run`=0, `core_reset`=0 (final state stays inspectable).
  - Results are held.
  - `start` restarts at RESET with results cleared.
- `start` is ignored in RESET, RUN and CHECK.
- An entry for register 0 is compared normally.
- Memory entries ignore address bits [1:0].

## Timing
- All outputs are registered, except `dbg_rf_addr` and `dbg_mem_addr`, which are combinational from the table inputs.
- `start` sampled at edge T: `core_reset` stays 1 through edge T+`RESET_CYCLES`. `core_run`=1 from T+`RESET_CYCLES` until the RUN exit edge.
- Without halt, total latency from `start` to `done`=1 is `RESET_CYCLES`+`RUN_CYCLES`+`NUM_CHECKS`+1 edges.
- Table and debug reads must settle within one cycle. The compare and the result update land on the same edge.
- `pass` is asserted only together with `done`.

## Test plan
- Default parameters, program expecting v0=7, v1=0xc, a0=1, a1=0xb, a3=7, s0=0x10000000, s1=0x1000000c, mem[0x10000050]=7, mem[0x10000054]=7, zero=0 (10 entries) -> `done` 87 edges after `start`, `pass`=1, `fail_count`=0, `first_fail`=10, `cycle_count`=75.
- Same program, entries 3 and 7 given wrong expected values -> `pass`=0, `fail_count`=2, `first_fail`=3.
- `HALT_EN`=1, `halt` asserted on RUN cycle 40 -> `cycle_count`=40, `halted`=1, `timeout`=0. With `halt` never asserted -> `cycle_count`=75, `timeout`=1.
- `halt` coincident with RUN cycle 75 -> `halted`=1, `timeout`=0, `cycle_count`=75.
- `reset` pulsed in RUN cycle 20, then in CHECK index 5 -> next cycle IDLE with all outputs at reset values. A later `start` gives a clean full run with correct results.
- `start` pulsed during RUN and during CHECK -> ignored, timing unchanged. `start` in DONE -> results clear and `busy`=1 on the next edge.
